// File: rtl/exec_sequencer.sv
// Multi-cycle execute controller: IDLE -> READ -> EXEC -> WB.
// Drives regfile selects, ALU operands/uop and writeback of result and flags.
module exec_sequencer #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 4,
  parameter int UOP_W  = 5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [3:0]        instr_cond,
  input  logic [UOP_W-1:0]  instr_uop,
  input  logic [REG_W-1:0]  instr_rd,
  input  logic [REG_W-1:0]  instr_rn,
  input  logic [REG_W-1:0]  instr_rm,
  input  logic              instr_use_imm,
  input  logic [DATA_W-1:0] instr_imm,
  input  logic              instr_wb,
  input  logic              instr_set_flags,
  output logic [REG_W-1:0]  sel_p0,
  output logic [REG_W-1:0]  sel_p1,
  input  logic [DATA_W-1:0] p0,
  input  logic [DATA_W-1:0] p1,
  output logic [REG_W-1:0]  sel_in,
  output logic [DATA_W-1:0] reg_wdata,
  output logic              reg_we,
  input  logic [3:0]        flags_cur,
  output logic [3:0]        flags_wr,
  output logic              flags_we,
  output logic [DATA_W-1:0] alu_lhs,
  output logic [DATA_W-1:0] alu_rhs,
  output logic [UOP_W-1:0]  alu_uop,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [3:0]        alu_flags,
  output logic              done,
  output logic              skipped
);

  typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;

  state_t              state_q, state_d;
  logic [UOP_W-1:0]    uop_q, uop_d;
  logic [REG_W-1:0]    rd_q, rd_d;
  logic                use_imm_q, use_imm_d;
  logic [DATA_W-1:0]   imm_q, imm_d;
  logic                wb_q, wb_d;
  logic                sf_q, sf_d;
  logic                skip_q, skip_d;
  logic [REG_W-1:0]    sel_p0_q, sel_p0_d;
  logic [REG_W-1:0]    sel_p1_q, sel_p1_d;
  logic [REG_W-1:0]    sel_in_q, sel_in_d;
  logic [DATA_W-1:0]   lhs_q, lhs_d;
  logic [DATA_W-1:0]   rhs_q, rhs_d;
  logic [DATA_W-1:0]   res_q, res_d;
  logic [3:0]          flg_q, flg_d;
  logic                accept;
  logic                pass;

  // flags layout is [Z,C,N,V]; code 1111 never passes
  function automatic logic cond_pass(input logic [3:0] c,
                                     input logic [3:0] f);
    logic z, cy, n, v;
    z  = f[3];
    cy = f[2];
    n  = f[1];
    v  = f[0];
    case (c)
      4'b0000: cond_pass = z;
      4'b0001: cond_pass = !z;
      4'b0010: cond_pass = cy;
      4'b0011: cond_pass = !cy;
      4'b0100: cond_pass = n;
      4'b0101: cond_pass = !n;
      4'b0110: cond_pass = v;
      4'b0111: cond_pass = !v;
      4'b1000: cond_pass = cy & !z;
      4'b1001: cond_pass = !cy | z;
      4'b1010: cond_pass = (n == v);
      4'b1011: cond_pass = (n != v);
      4'b1100: cond_pass = !z & (n == v);
      4'b1101: cond_pass = z | (n != v);
      4'b1110: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  endfunction

  assign instr_ready = (state_q == IDLE) & !reset;
  assign accept      = instr_valid & instr_ready;
  assign pass        = cond_pass(instr_cond, flags_cur);

  always_comb begin
    state_d   = state_q;
    uop_d     = uop_q;
    rd_d      = rd_q;
    use_imm_d = use_imm_q;
    imm_d     = imm_q;
    wb_d      = wb_q;
    sf_d      = sf_q;
    skip_d    = skip_q;
    sel_p0_d  = sel_p0_q;
    sel_p1_d  = sel_p1_q;
    sel_in_d  = sel_in_q;
    lhs_d     = lhs_q;
    rhs_d     = rhs_q;
    res_d     = res_q;
    flg_d     = flg_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          uop_d     = instr_uop;
          rd_d      = instr_rd;
          use_imm_d = instr_use_imm;
          imm_d     = instr_imm;
          wb_d      = instr_wb;
          sf_d      = instr_set_flags;
          skip_d    = !pass;
          if (pass) begin
            sel_p0_d = instr_rn;
            sel_p1_d = instr_rm;
            state_d  = READ;
          end else begin
            sel_in_d = instr_rd;
            state_d  = WB;
          end
        end
      end
      READ: begin
        lhs_d   = p0;
        rhs_d   = use_imm_q ? imm_q : p1;
        state_d = EXEC;
      end
      EXEC: begin
        res_d    = alu_result;
        flg_d    = alu_flags;
        sel_in_d = rd_q;
        state_d  = WB;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      uop_q     <= '0;
      rd_q      <= '0;
      use_imm_q <= 1'b0;
      imm_q     <= '0;
      wb_q      <= 1'b0;
      sf_q      <= 1'b0;
      skip_q    <= 1'b0;
      sel_p0_q  <= '0;
      sel_p1_q  <= '0;
      sel_in_q  <= '0;
      lhs_q     <= '0;
      rhs_q     <= '0;
      res_q     <= '0;
      flg_q     <= '0;
    end else begin
      state_q   <= state_d;
      uop_q     <= uop_d;
      rd_q      <= rd_d;
      use_imm_q <= use_imm_d;
      imm_q     <= imm_d;
      wb_q      <= wb_d;
      sf_q      <= sf_d;
      skip_q    <= skip_d;
      sel_p0_q  <= sel_p0_d;
      sel_p1_q  <= sel_p1_d;
      sel_in_q  <= sel_in_d;
      lhs_q     <= lhs_d;
      rhs_q     <= rhs_d;
      res_q     <= res_d;
      flg_q     <= flg_d;
    end
  end

  assign sel_p0    = sel_p0_q;
  assign sel_p1    = sel_p1_q;
  assign sel_in    = sel_in_q;
  assign reg_wdata = res_q;
  assign flags_wr  = flg_q;
  assign alu_lhs   = lhs_q;
  assign alu_rhs   = rhs_q;
  assign alu_uop   = uop_q;

  // strobes are suppressed while reset is held so an aborted WB never commits
  assign done     = (state_q == WB) & !reset;
  assign skipped  = done & skip_q;
  assign reg_we   = done & wb_q & !skip_q;
  assign flags_we = done & sf_q & !skip_q;

endmodule

// File: tb/tb_exec_sequencer.sv
// Directed bench for exec_sequencer with a behavioural regfile, flags and ALU.
module tb_exec_sequencer;

  localparam int DW = 32;
  localparam int RW = 4;
  localparam int UW = 5;

  logic          clock = 1'b0;
  logic          reset;
  logic          instr_valid;
  logic          instr_ready;
  logic [3:0]    instr_cond;
  logic [UW-1:0] instr_uop;
  logic [RW-1:0] instr_rd, instr_rn, instr_rm;
  logic          instr_use_imm;
  logic [DW-1:0] instr_imm;
  logic          instr_wb, instr_set_flags;
  logic [RW-1:0] sel_p0, sel_p1, sel_in;
  logic [DW-1:0] p0, p1, reg_wdata;
  logic          reg_we;
  logic [3:0]    flags_cur, flags_wr;
  logic          flags_we;
  logic [DW-1:0] alu_lhs, alu_rhs, alu_result;
  logic [UW-1:0] alu_uop;
  logic [3:0]    alu_flags;
  logic          done, skipped;

  logic [DW-1:0] regs [16];
  logic [3:0]    flags_q;
  int            errors = 0;
  int            checks = 0;
  int            ndone;

  always #5 clock = ~clock;

  exec_sequencer dut (
    .clock(clock), .reset(reset),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_cond(instr_cond), .instr_uop(instr_uop),
    .instr_rd(instr_rd), .instr_rn(instr_rn), .instr_rm(instr_rm),
    .instr_use_imm(instr_use_imm), .instr_imm(instr_imm),
    .instr_wb(instr_wb), .instr_set_flags(instr_set_flags),
    .sel_p0(sel_p0), .sel_p1(sel_p1), .p0(p0), .p1(p1),
    .sel_in(sel_in), .reg_wdata(reg_wdata), .reg_we(reg_we),
    .flags_cur(flags_cur), .flags_wr(flags_wr), .flags_we(flags_we),
    .alu_lhs(alu_lhs), .alu_rhs(alu_rhs), .alu_uop(alu_uop),
    .alu_result(alu_result), .alu_flags(alu_flags),
    .done(done), .skipped(skipped)
  );

  // environment: r0=2, r1=1 after reset, flags cleared
  always @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) regs[i] <= '0;
      regs[0] <= 32'd2;
      regs[1] <= 32'd1;
      flags_q <= 4'b0000;
    end else begin
      if (reg_we) regs[sel_in] <= reg_wdata;
      if (flags_we) flags_q <= flags_wr;
    end
  end

  assign p0 = regs[sel_p0];
  assign p1 = regs[sel_p1];
  assign flags_cur = flags_q;

  // uop 1 = ADD, uop 2 = SUB (C = no borrow)
  always_comb begin
    logic [DW:0] t;
    logic        c, v;
    t = '0;
    c = 1'b0;
    v = 1'b0;
    case (alu_uop)
      5'd1: begin
        t = {1'b0, alu_lhs} + {1'b0, alu_rhs};
        c = t[DW];
        v = (alu_lhs[DW-1] == alu_rhs[DW-1]) &&
            (t[DW-1] != alu_lhs[DW-1]);
      end
      5'd2: begin
        t = {1'b0, alu_lhs} - {1'b0, alu_rhs};
        c = (alu_lhs >= alu_rhs);
        v = (alu_lhs[DW-1] != alu_rhs[DW-1]) &&
            (t[DW-1] != alu_lhs[DW-1]);
      end
      default: t = '0;
    endcase
    alu_result = t[DW-1:0];
    alu_flags  = {(t[DW-1:0] == '0), c, t[DW-1], v};
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [3:0] cond, input logic [UW-1:0] uop,
                       input logic [RW-1:0] rd, input logic [RW-1:0] rn,
                       input logic [RW-1:0] rm, input logic ui,
                       input logic [DW-1:0] imm, input logic wb,
                       input logic sf);
    instr_cond      = cond;
    instr_uop       = uop;
    instr_rd        = rd;
    instr_rn        = rn;
    instr_rm        = rm;
    instr_use_imm   = ui;
    instr_imm       = imm;
    instr_wb        = wb;
    instr_set_flags = sf;
    instr_valid     = 1'b1;
  endtask

  // present at a negedge, accept at the next posedge, return at the
  // following negedge (T+1)
  task automatic send(input logic [3:0] cond, input logic [UW-1:0] uop,
                      input logic [RW-1:0] rd, input logic [RW-1:0] rn,
                      input logic [RW-1:0] rm, input logic ui,
                      input logic [DW-1:0] imm, input logic wb,
                      input logic sf);
    drive(cond, uop, rd, rn, rm, ui, imm, wb, sf);
    chk("ready_at_accept", 32'(instr_ready), 32'd1);
    @(posedge clock);
    @(negedge clock);
    instr_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    instr_valid = 1'b0;
    drive(4'd0, '0, '0, '0, '0, 1'b0, '0, 1'b0, 1'b0);
    instr_valid = 1'b0;
    @(posedge clock);
    @(posedge clock);
    @(negedge clock);
    chk("rst_ready", 32'(instr_ready), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_reg_we", 32'(reg_we), 32'd0);
    chk("rst_flags_we", 32'(flags_we), 32'd0);
    chk("rst_sel_p0", 32'(sel_p0), 32'd0);
    chk("rst_alu_lhs", alu_lhs, 32'd0);
    chk("rst_wdata", reg_wdata, 32'd0);
    chk("rst_flags_wr", 32'(flags_wr), 32'd0);
    reset = 1'b0;
    #1;
    chk("post_rst_ready", 32'(instr_ready), 32'd1);
    @(negedge clock);

    // EQ with Z=0 -> skipped
    send(4'b0000, 5'd2, 4'd5, 4'd1, 4'd0, 1'b0, '0, 1'b1, 1'b1);
    chk("skip_done", 32'(done), 32'd1);
    chk("skip_skipped", 32'(skipped), 32'd1);
    chk("skip_reg_we", 32'(reg_we), 32'd0);
    chk("skip_flags_we", 32'(flags_we), 32'd0);
    chk("skip_ready_wb", 32'(instr_ready), 32'd0);
    @(negedge clock);
    chk("skip_ready_t2", 32'(instr_ready), 32'd1);
    chk("skip_done_t2", 32'(done), 32'd0);

    // SUB r2 = r1 - r0 = 1 - 2, S=1, AL
    send(4'b1110, 5'd2, 4'd2, 4'd1, 4'd0, 1'b0, '0, 1'b1, 1'b1);
    chk("sub_sel_p0", 32'(sel_p0), 32'd1);
    chk("sub_sel_p1", 32'(sel_p1), 32'd0);
    chk("sub_ready_read", 32'(instr_ready), 32'd0);
    @(negedge clock);
    chk("sub_lhs", alu_lhs, 32'd1);
    chk("sub_rhs", alu_rhs, 32'd2);
    chk("sub_uop", 32'(alu_uop), 32'd2);
    chk("sub_ready_exec", 32'(instr_ready), 32'd0);
    chk("sub_done_exec", 32'(done), 32'd0);
    @(negedge clock);
    chk("sub_reg_we", 32'(reg_we), 32'd1);
    chk("sub_sel_in", 32'(sel_in), 32'd2);
    chk("sub_wdata", reg_wdata, 32'hFFFF_FFFF);
    chk("sub_flags_we", 32'(flags_we), 32'd1);
    chk("sub_flags_wr", 32'(flags_wr), 32'b0010);
    chk("sub_done", 32'(done), 32'd1);
    chk("sub_skipped", 32'(skipped), 32'd0);
    @(negedge clock);
    chk("sub_ready_t4", 32'(instr_ready), 32'd1);
    chk("sub_done_t4", 32'(done), 32'd0);
    chk("sub_r2", regs[2], 32'hFFFF_FFFF);

    // compare r0 - r0, wb=0, S=1 -> Z=1, C=1
    send(4'b1110, 5'd2, 4'd3, 4'd0, 4'd0, 1'b0, '0, 1'b0, 1'b1);
    @(negedge clock);
    @(negedge clock);
    chk("cmp_reg_we", 32'(reg_we), 32'd0);
    chk("cmp_flags_we", 32'(flags_we), 32'd1);
    chk("cmp_flags_wr", 32'(flags_wr), 32'b1100);
    chk("cmp_done", 32'(done), 32'd1);
    @(negedge clock);

    // ADD r4 = r0 + imm 0x10 under EQ (Z=1 now)
    send(4'b0000, 5'd1, 4'd4, 4'd0, 4'd1, 1'b1, 32'h10, 1'b1, 1'b0);
    chk("imm_not_skipped", 32'(done), 32'd0);
    @(negedge clock);
    chk("imm_lhs", alu_lhs, 32'd2);
    chk("imm_rhs", alu_rhs, 32'h10);
    @(negedge clock);
    chk("imm_wdata", reg_wdata, 32'h12);
    chk("imm_reg_we", 32'(reg_we), 32'd1);
    chk("imm_flags_we", 32'(flags_we), 32'd0);
    chk("imm_sel_in", 32'(sel_in), 32'd4);
    @(negedge clock);

    // back-to-back with valid held high
    ndone = 0;
    drive(4'b1110, 5'd1, 4'd5, 4'd0, 4'd1, 1'b0, '0, 1'b1, 1'b0);
    for (int k = 0; k < 12; k++) begin
      chk($sformatf("b2b_ready_%0d", k), 32'(instr_ready),
          32'((k % 4) == 0));
      chk($sformatf("b2b_done_%0d", k), 32'(done),
          32'((k % 4) == 3));
      if (done) ndone++;
      @(posedge clock);
      @(negedge clock);
    end
    instr_valid = 1'b0;
    chk("b2b_ndone", 32'(ndone), 32'd3);
    chk("b2b_r5", regs[5], 32'd3);

    // reset during EXEC aborts the instruction
    send(4'b1110, 5'd2, 4'd6, 4'd1, 4'd0, 1'b0, '0, 1'b1, 1'b1);
    @(negedge clock);
    chk("abort_in_exec", alu_lhs, 32'd1);
    reset = 1'b1;
    @(negedge clock);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_reg_we", 32'(reg_we), 32'd0);
    chk("abort_flags_we", 32'(flags_we), 32'd0);
    chk("abort_ready", 32'(instr_ready), 32'd0);
    chk("abort_lhs", alu_lhs, 32'd0);
    chk("abort_rhs", alu_rhs, 32'd0);
    chk("abort_uop", 32'(alu_uop), 32'd0);
    chk("abort_sel_p0", 32'(sel_p0), 32'd0);
    chk("abort_sel_in", 32'(sel_in), 32'd0);
    chk("abort_flags_wr", 32'(flags_wr), 32'd0);
    reset = 1'b0;
    #1;
    chk("abort_ready_after", 32'(instr_ready), 32'd1);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("abort_idle_done_%0d", k), 32'(done), 32'd0);
      chk($sformatf("abort_idle_we_%0d", k), 32'(reg_we), 32'd0);
      @(negedge clock);
    end

    send(4'b1110, 5'd2, 4'd2, 4'd1, 4'd0, 1'b0, '0, 1'b1, 1'b1);
    @(negedge clock);
    @(negedge clock);
    chk("again_reg_we", 32'(reg_we), 32'd1);
    chk("again_wdata", reg_wdata, 32'hFFFF_FFFF);
    chk("again_flags_wr", 32'(flags_wr), 32'b0010);
    chk("again_done", 32'(done), 32'd1);
    @(negedge clock);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/exec_sequencer.md
Name: exec_sequencer

Overview:
- Multi-cycle execute controller. Sits directly upstream of the register file (`regs`) and the `ALU`, and drives their selects, operands and micro-op.
- Accepts one decoded instruction per valid/ready handshake and evaluates its ARM condition code against the current flags.
- Sequences register read, ALU execute and writeback of the result and flags.
- Replaces hand-driven sel_in/sel_p0/sel_p1/uop/flags_in sequencing with a deterministic 4-state FSM.

Parameters:
- DATA_W, 32, datapath width (registers, ALU operands, immediate).
- REG_W, 4, register index width (16 registers).
- UOP_W, 5, ALU micro-op width.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- instr_valid  in  1  decoded instruction present.
- instr_ready  out  1  sequencer can accept an instruction.
- instr_cond  in  4  ARM condition code.
- instr_uop  in  UOP_W  ALU micro-op.
- instr_rd / instr_rn / instr_rm  in  REG_W each  dest / LHS source / RHS source register.
- instr_use_imm  in  1  RHS = instr_imm instead of rm.
- instr_imm  in  DATA_W  immediate operand.
- instr_wb  in  1  write result to rd (0 for compare-type ops).
- instr_set_flags  in  1  update flags (S bit).
- sel_p0 / sel_p1  out  REG_W each  register file read selects.
- p0 / p1  in  DATA_W each  register file read data (combinational read).
- sel_in  out  REG_W  register file write select.
- reg_wdata  out  DATA_W  register file write data.
- reg_we  out  1  register file write enable.
- flags_cur  in  4  current flags [Z,C,N,V] (bit3=Z, bit2=C, bit1=N, bit0=V).
- flags_wr  out  4  flags to commit.
- flags_we  out  1  flags write enable.
- alu_lhs / alu_rhs  out  DATA_W each  ALU operands.
- alu_uop  out  UOP_W  ALU micro-op.
- alu_result  in  DATA_W  ALU result.
- alu_flags  in  4  ALU flags [Z,C,N,V].
- done  out  1  one-cycle pulse at instruction retirement.
- skipped  out  1  qualifies done: condition failed, no writes performed.

Behaviour:
- Reset (synchronous) forces:
  - state IDLE;
  - all captured fields, selects, alu_*, reg_wdata and flags_wr = 0;
  - reg_we = flags_we = done = skipped = 0;
  - instr_ready = 0 while reset is high, 1 in the first cycle after reset.
- States: IDLE, READ, EXEC, WB. instr_ready = (state==IDLE), combinational.
- IDLE, accept when instr_valid & instr_ready:
  - capture all instr_* fields;
  - evaluate the condition on flags_cur in the same cycle;
  - pass -> READ; fail -> WB with skip flag set.
- Condition codes:
  - EQ 0000: Z; NE 0001: !Z.
  - CS 0010: C; CC 0011: !C.
  - MI 0100: N; PL 0101: !N.
  - VS 0110: V; VC 0111: !V.
  - HI 1000: C&!Z; LS 1001: !C|Z.
  - GE 1010: N==V; LT 1011: N!=V.
  - GT 1100: !Z&(N==V); LE 1101: Z|(N!=V).
  - AL 1110: always; 1111: never (treated as fail).
- READ:
  - sel_p0 = rn, sel_p1 = rm;
  - at the clock edge, latch lhs_q = p0 and rhs_q = (use_imm ? imm : p1);
  - -> EXEC.
- EXEC:
  - alu_lhs = lhs_q, alu_rhs = rhs_q, alu_uop = captured uop, all registered and stable the whole cycle;
  - at the clock edge, latch res_q = alu_result and flg_q = alu_flags;
  - -> WB.
- WB:
  - sel_in = rd, reg_wdata = res_q, reg_we = wb & !skip;
  - flags_wr = flg_q, flags_we = set_flags & !skip;
  - done = 1, skipped = skip;
  - -> IDLE.
- Latency, accept at cycle T:
  - executed instruction: writes/done in T+3, next accept earliest T+4;
  - skipped instruction: done and skipped in T+1, no writes, next accept T+2.
- reg_we, flags_we and done are asserted only in WB, exactly one cycle per instruction.
- Outside READ/WB, sel_p0/sel_p1/sel_in hold their last value; the write is gated by reg_we.
- No hazards: writes commit at the WB edge, before the next instruction's condition evaluation or register read.
- Reset asserted in any state:
  - abort next edge with no reg_we/flags_we/done;
  - the in-flight instruction is dropped.
- instr_valid while busy is ignored (ready=0). Upstream holds fields stable until accepted.

Test Plan:
1. r0=2, r1=1; accept SUB (uop 00010) rd=2, rn=1, rm=0, S=1, cond AL -> in T+3: reg_we=1, sel_in=2, reg_wdata=32'hFFFFFFFF, flags_we=1, flags_wr = alu_flags sampled in EXEC; done=1, skipped=0.
2. flags_cur=4'b0000, cond EQ -> T+1: done=1, skipped=1, reg_we=0, flags_we=0; instr_ready=1 at T+2.
3. Compare-type SUB, wb=0, S=1, rn=rm=r0 -> T+3: reg_we=0, flags_we=1, flags_wr Z bit = 1.
4. use_imm=1, imm=32'h10, rn=r0 (=2) -> in EXEC: alu_lhs=2, alu_rhs=32'h10 regardless of p1.
5. instr_valid held high with 3 instructions -> accepts at T, T+4, T+8; instr_ready=0 in all READ/EXEC/WB cycles; exactly 3 done pulses.
6. reset pulsed during EXEC -> no reg_we/flags_we/done afterwards, all outputs 0; instr_ready=1 the cycle after reset drops; next instruction executes normally.
